// File: rtl/ram_1kx8_if.sv
// Access bus for the 1024x8 byte store: select/write/address/data_in in, data_out/ready back.
// Master drives the access controls; slave returns registered read data and readiness.
interface ram_1kx8_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W-1:0] address;
    logic              write;
    logic              select;
    logic              ready;

    modport master (
        output data_in, address, write, select,
        input  data_out, ready
    );

    modport slave (
        input  data_in, address, write, select,
        output data_out, ready
    );
endinterface

// File: rtl/ram_1kx8.sv
// Single-port 2^ADDR_W x DATA_W synchronous RAM; zeroes itself after reset (CLEAR), then serves accesses (RUN).
// Latency: reads registered, data_out valid one edge after the access is sampled; CLEAR takes 2^ADDR_W edges.
// Backpressure: none beyond ready; accesses ignored until ready=1. RAM_WRITE_THROUGH_EN: writes also load data_out.
module ram_1kx8 #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_1kx8_if.slave     bus
);
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] data_out_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdat;
    logic              rd_en;
    logic              wt_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        mem_we      = 1'b0;
        mem_addr    = bus.address;
        mem_wdat    = bus.data_in;
        rd_en       = 1'b0;
        wt_en       = 1'b0;
        unique case (state)
            CLEAR: begin
                // user accesses are dropped; the sweep owns the write port
                mem_we      = 1'b1;
                mem_addr    = clr_cnt;
                mem_wdat    = '0;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == {ADDR_W{1'b1}}) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.select && bus.write) begin
                    mem_we = 1'b1;
`ifdef RAM_WRITE_THROUGH_EN
                    wt_en  = 1'b1;
`else
                    wt_en  = 1'b0;
`endif
                end else if (bus.select) begin
                    rd_en = 1'b1;
                end
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    // array has no reset: only the CLEAR sweep zeroes it
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
        end else if (rd_en) begin
            data_out_q <= mem[bus.address];
        end else if (wt_en) begin
            data_out_q <= bus.data_in;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.ready    = (state == RUN);
endmodule

// File: tb/tb_ram_1kx8.sv
// Scoreboard bench for ram_1kx8: a model array predicts data_out, expectations queue per issued cycle.
module tb_ram_1kx8;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_1kx8_if #(.ADDR_W(10), .DATA_W(8)) bus ();

    ram_1kx8 #(.ADDR_W(10), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model [1024];
    logic [7:0] exp_q [$];
    logic [7:0] last_dout;
    bit         in_run;
    logic [7:0] got;
    logic [7:0] exp;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) model[i] = 8'h00;
        exp_q.delete();
        last_dout = 8'h00;
        in_run    = 1'b0;
    endtask

    task automatic issue_rd(input logic [9:0] a);
        bus.select  = 1'b1;
        bus.write   = 1'b0;
        bus.address = a;
        bus.data_in = 8'($urandom);
        if (in_run) last_dout = model[a];
        exp_q.push_back(last_dout);
        step();
    endtask

    task automatic issue_wr(input logic [9:0] a, input logic [7:0] d);
        bus.select  = 1'b1;
        bus.write   = 1'b1;
        bus.address = a;
        bus.data_in = d;
        if (in_run) begin
            model[a] = d;
`ifdef RAM_WRITE_THROUGH_EN
            last_dout = d;
`endif
        end
        exp_q.push_back(last_dout);
        step();
    endtask

    task automatic issue_idle();
        bus.select  = 1'b0;
        bus.write   = 1'($urandom);
        bus.address = 10'($urandom);
        bus.data_in = 8'($urandom);
        exp_q.push_back(last_dout);
        step();
    endtask

    // Releases reset away from the clock edge and counts edges until ready; optionally pokes 0xFF at 1023.
    task automatic run_clear(input bit poke, output int n);
        rst_n = 1'b1;
        n = 0;
        while (!bus.ready && n < 2000) begin
            bus.select  = poke;
            bus.write   = 1'b1;
            bus.address = 10'd1023;
            bus.data_in = 8'hFF;
            step();
            n++;
        end
        bus.select = 1'b0;
        in_run = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        bus.select = 1'b0; bus.write = 1'b0; bus.address = '0; bus.data_in = '0;
        model_reset();
        #1;
        checks++;
        if (bus.data_out !== 8'h00 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state data_out=%h ready=%b required 00/0", bus.data_out, bus.ready);
        end
        #13;
        run_clear(1'b1, n);
        checks++;
        if (n !== 1024) begin
            errors++;
            $display("FAIL clear_len edges=%0d required 1024", n);
        end
        checks++;
        if (bus.data_out !== 8'h00) begin
            errors++;
            $display("FAIL clear_hold data_out=%h required 00", bus.data_out);
        end
    endtask

    task automatic test_cleared_reads();
        logic [9:0] addrs [4];
        addrs = '{10'd0, 10'd512, 10'd1023, 10'd77};
        for (int i = 0; i < 4; i++) begin
            issue_rd(addrs[i]);
            got = bus.data_out;
            exp = exp_q.pop_front();
            checks++;
            if (got !== 8'h00 || got !== exp) begin
                errors++;
                $display("FAIL cleared_rd addr=%0d got %h required 00", addrs[i], got);
            end
        end
    endtask

    task automatic test_fill();
        logic [9:0] addrs [3];
        logic [7:0] vals  [3];
        addrs = '{10'd5, 10'd200, 10'd1023};
        vals  = '{8'd10, 8'd144, 8'd254};
        for (int k = 0; k < 1024; k++) begin
            issue_wr(10'(k), 8'(2 * k));
            got = bus.data_out;
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL fill_wr k=%0d data_out %h required %h", k, got, exp);
            end
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            issue_rd(addrs[i]);
            got = bus.data_out;
            exp = exp_q.pop_front();
            checks++;
            if (got !== vals[i] || got !== exp) begin
                errors++;
                $display("FAIL fill_rd addr=%0d got %h required %h", addrs[i], got, vals[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        issue_wr(10'd7, 8'hA5);
        got = bus.data_out;
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL wr_edge_dout got %h required %h", got, exp);
        end
        issue_rd(10'd7);
        got = bus.data_out;
        exp = exp_q.pop_front();
        checks++;
        if (got !== 8'hA5 || got !== exp) begin
            errors++;
            $display("FAIL wr_then_rd got %h required a5", got);
        end
    endtask

    task automatic test_deselect();
        issue_wr(10'd300, 8'h3C);
        void'(exp_q.pop_front());
        issue_rd(10'd300);
        got = bus.data_out;
        exp = exp_q.pop_front();
        checks++;
        if (got !== 8'h3C || got !== exp) begin
            errors++;
            $display("FAIL desel_rd got %h required 3c", got);
        end
        for (int c = 0; c < 10; c++) begin
            issue_idle();
            got = bus.data_out;
            exp = exp_q.pop_front();
            checks++;
            if (got !== 8'h3C || got !== exp) begin
                errors++;
                $display("FAIL desel_hold cycle=%0d got %h required 3c", c, got);
            end
        end
        for (int a = 0; a < 1024; a++) begin
            issue_rd(10'(a));
            got = bus.data_out;
            exp = exp_q.pop_front();
            if (got !== exp) begin
                errors++;
                $display("FAIL readback addr=%0d got %h required %h", a, got, exp);
            end
        end
        checks++;
    endtask

    task automatic test_reset_mid_run();
        int n;
        issue_wr(10'd50, 8'h77);
        void'(exp_q.pop_front());
        issue_rd(10'd50);
        void'(exp_q.pop_front());
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.data_out !== 8'h00 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL run_rst_state data_out=%h ready=%b required 00/0", bus.data_out, bus.ready);
        end
        model_reset();
        run_clear(1'b0, n);
        checks++;
        if (n !== 1024) begin
            errors++;
            $display("FAIL run_rst_len edges=%0d required 1024", n);
        end
        issue_rd(10'd50);
        got = bus.data_out;
        exp = exp_q.pop_front();
        checks++;
        if (got !== 8'h00 || got !== exp) begin
            errors++;
            $display("FAIL run_rst_data got %h required 00", got);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        repeat (300) step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.data_out !== 8'h00 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_rst_state data_out=%h ready=%b required 00/0", bus.data_out, bus.ready);
        end
        run_clear(1'b0, n);
        checks++;
        if (n !== 1024) begin
            errors++;
            $display("FAIL clr_rst_len edges=%0d required 1024", n);
        end
        issue_rd(10'd1023);
        got = bus.data_out;
        exp = exp_q.pop_front();
        checks++;
        if (got !== 8'h00 || got !== exp) begin
            errors++;
            $display("FAIL clr_rst_data got %h required 00", got);
        end
    endtask

    task automatic test_write_through();
        issue_rd(10'd0);
        void'(exp_q.pop_front());
        issue_wr(10'd9, 8'h5A);
        got = bus.data_out;
        exp = exp_q.pop_front();
        checks++;
`ifdef RAM_WRITE_THROUGH_EN
        if (got !== 8'h5A || got !== exp) begin
`else
        if (got !== 8'h00 || got !== exp) begin
`endif
            errors++;
            $display("FAIL wt_dout got %h required %h", got, exp);
        end
        issue_rd(10'd9);
        got = bus.data_out;
        exp = exp_q.pop_front();
        checks++;
        if (got !== 8'h5A || got !== exp) begin
            errors++;
            $display("FAIL wt_rd got %h required 5a", got);
        end
    endtask

    initial begin
        test_reset();
        test_cleared_reads();
        test_fill();
        test_back_to_back();
        test_deselect();
        test_reset_mid_run();
        test_reset_mid_clear();
        test_write_through();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
